// File: rtl/rr_sound_scheduler_if.sv
// Game-side bundle for the sound scheduler.
// The game logic drives music_on and the request pulses; the scheduler drives the audio controls back.
interface rr_sound_scheduler_if;
   logic       music_on;
   logic       req_crash;
   logic       req_fuel;
   logic       req_bonus;
   logic       music_enable;
   logic       sfx_speaker;
   logic       busy;
   logic [1:0] active_id;

   modport master (
      output music_on, req_crash, req_fuel, req_bonus,
      input  music_enable, sfx_speaker, busy, active_id
   );

   modport slave (
      input  music_on, req_crash, req_fuel, req_bonus,
      output music_enable, sfx_speaker, busy, active_id
   );
endinterface

// File: rtl/rr_sound_scheduler.sv
// Shares the single audio path between background music and three prioritised one-shot effects.
// Each effect is a stepped square-wave sweep, followed by a short silent gap.
module rr_sound_scheduler #(
   parameter int TICK_DIV    = 520833,
   parameter int PRESCALE    = 16,
   parameter int CRASH_STEPS = 16,
   parameter int FUEL_STEPS  = 8,
   parameter int BONUS_STEPS = 12,
   parameter int GAP_STEPS   = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   rr_sound_scheduler_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = 8;
   localparam int HW = 13 + $clog2(PRESCALE);

   state_t        state_q, state_d;
   logic [2:0]    pend_q, pend_d;
   logic [1:0]    act_q, act_d;
   logic          busy_q, busy_d;
   logic          men_q, men_d;
   logic          spk_q, spk_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [SW-1:0] step_q, step_d;
   logic [HW-1:0] hc_q, hc_d;
   logic [HW-1:0] lim;
   logic          tick;
   logic          launch;
   logic [1:0]    hi_id;
   logic [2:0]    req;
   logic [2:0]    clr;

   function automatic logic [11:0] period(input logic [1:0] id, input logic [SW-1:0] n);
      logic [11:0] p;
      case (id)
         2'd3:    p = 12'h200 + 12'h040 * 12'(n);
         2'd2:    p = n[0] ? 12'h600 : 12'h300;
         2'd1:    p = 12'h400 - 12'h020 * 12'(n);
         default: p = 12'h000;
      endcase
      return p;
   endfunction

   function automatic logic [SW-1:0] last_step(input logic [1:0] id);
      logic [SW-1:0] s;
      case (id)
         2'd3:    s = SW'(CRASH_STEPS - 1);
         2'd2:    s = SW'(FUEL_STEPS - 1);
         default: s = SW'(BONUS_STEPS - 1);
      endcase
      return s;
   endfunction

   assign req  = {bus.req_crash, bus.req_fuel, bus.req_bonus};
   assign tick = (tick_q == TW'(TICK_DIV - 1));

   always_comb begin
      hi_id = 2'd0;
      if (pend_q[2])      hi_id = 2'd3;
      else if (pend_q[1]) hi_id = 2'd2;
      else if (pend_q[0]) hi_id = 2'd1;
   end

   // State register and all counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         act_q   <= '0;
         busy_q  <= 1'b0;
         men_q   <= 1'b0;
         spk_q   <= 1'b0;
         tick_q  <= '0;
         step_q  <= '0;
         hc_q    <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         busy_q  <= busy_d;
         men_q   <= men_d;
         spk_q   <= spk_d;
         tick_q  <= tick_d;
         step_q  <= step_d;
         hc_q    <= hc_d;
      end
   end

   // Next state; launch covers first start, preemption and start from the gap
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_PLAY;
               launch  = 1'b1;
            end
         end
         S_PLAY: begin
            if (hi_id > act_q) launch = 1'b1;
            else if (tick && step_q == last_step(act_q)) state_d = S_GAP;
         end
         S_GAP: begin
            if (tick && step_q == SW'(GAP_STEPS - 1)) begin
               if (|pend_q) begin
                  state_d = S_PLAY;
                  launch  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs; music_enable deliberately lags the state by one cycle
   always_comb begin
      act_d  = (state_d == S_PLAY) ? (launch ? hi_id : act_q) : 2'd0;
      busy_d = (state_d != S_IDLE);
      men_d  = bus.music_on && (state_q == S_IDLE);
   end

   // A request on the launch edge of its own kind survives the clear and replays later
   always_comb begin
      clr    = launch ? {hi_id == 2'd3, hi_id == 2'd2, hi_id == 2'd1} : 3'b000;
      pend_d = (pend_q & ~clr) | req;
      lim    = HW'(period(act_q, step_q)) * HW'(PRESCALE) - HW'(1);
      tick_d = '0;
      step_d = '0;
      hc_d   = '0;
      spk_d  = 1'b0;
      if (!launch && state_q != S_IDLE) begin
         tick_d = tick ? '0 : tick_q + TW'(1);
         if (tick) step_d = (state_d == state_q) ? step_q + SW'(1) : '0;
         else      step_d = step_q;
         if (state_q == S_PLAY && state_d == S_PLAY && !tick) begin
            if (hc_q == lim) begin
               hc_d  = '0;
               spk_d = ~spk_q;
            end else begin
               hc_d  = hc_q + HW'(1);
               spk_d = spk_q;
            end
         end
      end
   end

   assign bus.music_enable = men_q;
   assign bus.sfx_speaker  = spk_q;
   assign bus.busy         = busy_q;
   assign bus.active_id    = act_q;
endmodule

// File: tb/tb_rr_sound_scheduler.sv
// Scoreboard bench: stimulus queues the expected output changes (cycle, outputs);
// per-DUT monitors pop and compare on every change of {busy, active_id, music_enable, sfx_speaker}.
module tb_rr_sound_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst2;
   rr_sound_scheduler_if sif1();
   rr_sound_scheduler_if sif2();

   rr_sound_scheduler #(.TICK_DIV(4), .PRESCALE(1)) dut1 (
      .clock (clk),
      .reset (rst1),
      .bus   (sif1)
   );

   rr_sound_scheduler #(.TICK_DIV(2500), .PRESCALE(2)) dut2 (
      .clock (clk),
      .reset (rst2),
      .bus   (sif2)
   );

   typedef struct {
      int         cyc;
      logic [4:0] tup;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   bit   done1  = 1'b0;
   bit   done2  = 1'b0;

   logic [4:0] cur1, prev1 = 5'b0, cur2, prev2 = 5'b0;
   exp_t       e1, e2;
   bit         h1, h2;

   always @(posedge clk) cyc++;

   task automatic go(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare(input string nm, input bit have, input exp_t e, input int c,
                          input logic [4:0] got);
      n_vec++;
      if (!have) begin
         n_bad++;
         $display("FAIL %s unexpected change at cyc=%0d outputs=%b", nm, c, got);
      end else if (e.cyc != c || e.tup !== got) begin
         n_bad++;
         $display("FAIL %s got cyc=%0d outputs=%b, required cyc=%0d outputs=%b",
                  nm, c, got, e.cyc, e.tup);
      end
   endtask

   task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%b required=%b", nm, got, want);
      end
   endtask

   task automatic exp1(input int c, input logic [4:0] t);
      q1.push_back('{cyc: c, tup: t});
   endtask

   task automatic exp2(input int c, input logic [4:0] t);
      q2.push_back('{cyc: c, tup: t});
   endtask

   // which: 3=crash, 2=fuel, 1=bonus; the pulse is sampled on edge c+1
   task automatic pulse1(input int c, input int which);
      go(c);
      sif1.req_crash = (which == 3);
      sif1.req_fuel  = (which == 2);
      sif1.req_bonus = (which == 1);
      go(c + 1);
      sif1.req_crash = 1'b0;
      sif1.req_fuel  = 1'b0;
      sif1.req_bonus = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         cur1 = {sif1.busy, sif1.active_id, sif1.music_enable, sif1.sfx_speaker};
         if (cur1 !== prev1) begin
            h1 = (q1.size() > 0);
            e1 = h1 ? q1.pop_front() : '{cyc: 0, tup: 5'b0};
            compare("dut1_outputs", h1, e1, cyc, cur1);
            prev1 = cur1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         cur2 = {sif2.busy, sif2.active_id, sif2.music_enable, sif2.sfx_speaker};
         if (cur2 !== prev2) begin
            h2 = (q2.size() > 0);
            e2 = h2 ? q2.pop_front() : '{cyc: 0, tup: 5'b0};
            compare("dut2_tone", h2, e2, cyc, cur2);
            prev2 = cur2;
         end
      end
   end

   // Tuple bits: {busy, active_id[1:0], music_enable, sfx_speaker}
   initial begin
      rst1 = 1'b1;
      sif1.music_on  = 1'b1;
      sif1.req_crash = 1'b0;
      sif1.req_fuel  = 1'b0;
      sif1.req_bonus = 1'b0;
      go(1);
      mon_en = 1'b1;
      go(2);
      chk("reset_busy", {1'b0, sif1.busy}, 2'b00);
      chk("reset_active_id", sif1.active_id, 2'b00);
      chk("reset_music_enable", {1'b0, sif1.music_enable}, 2'b00);
      chk("reset_sfx_speaker", {1'b0, sif1.sfx_speaker}, 2'b00);
      exp1(4, 5'b00010);
      go(3);
      rst1 = 1'b0;

      exp1(11, 5'b00000);
      exp1(16, 5'b00010);
      go(10);
      sif1.music_on = 1'b0;
      go(15);
      sif1.music_on = 1'b1;

      // lone bonus: 12 steps x 4 cycles, then 8-cycle gap
      exp1(22, 5'b10110); exp1(23, 5'b10100); exp1(70, 5'b10000);
      exp1(78, 5'b00000); exp1(79, 5'b00010);
      pulse1(20, 1);

      // crash preempts bonus during its step 3; bonus is dropped
      exp1(102, 5'b10110); exp1(103, 5'b10100); exp1(116, 5'b11100);
      exp1(180, 5'b10000); exp1(188, 5'b00000); exp1(189, 5'b00010);
      pulse1(100, 1);
      pulse1(114, 3);

      // fuel and bonus wait behind crash, then play in priority order
      exp1(202, 5'b11110); exp1(203, 5'b11100); exp1(266, 5'b10000);
      exp1(274, 5'b11000); exp1(306, 5'b10000); exp1(314, 5'b10100);
      exp1(362, 5'b10000); exp1(370, 5'b00000); exp1(371, 5'b00010);
      pulse1(200, 3);
      pulse1(210, 2);
      pulse1(214, 1);

      // three fuel requests while pending collapse to a single play
      exp1(402, 5'b11110); exp1(403, 5'b11100); exp1(466, 5'b10000);
      exp1(474, 5'b11000); exp1(506, 5'b10000); exp1(514, 5'b00000);
      exp1(515, 5'b00010);
      pulse1(400, 3);
      pulse1(410, 2);
      pulse1(412, 2);
      pulse1(414, 2);

      // fuel re-requested while active replays; bonus on the PLAY->GAP edge stays pending
      exp1(552, 5'b11010); exp1(553, 5'b11000); exp1(584, 5'b10000);
      exp1(592, 5'b11000); exp1(624, 5'b10000); exp1(632, 5'b10100);
      exp1(680, 5'b10000); exp1(688, 5'b00000); exp1(689, 5'b00010);
      pulse1(550, 2);
      pulse1(560, 2);
      pulse1(583, 1);

      // reset mid-crash with fuel pending: nothing resumes afterwards
      exp1(702, 5'b11110); exp1(703, 5'b11100); exp1(721, 5'b00000);
      exp1(723, 5'b00010);
      pulse1(700, 3);
      pulse1(710, 2);
      go(720);
      rst1 = 1'b1;
      go(722);
      rst1 = 1'b0;
      go(850);
      done1 = 1'b1;
   end

   // Slow instance: crash step 0 (P=0x200, PRESCALE 2) toggles every 1024 cycles, step 1 after 1152
   initial begin
      rst2 = 1'b1;
      sif2.music_on  = 1'b0;
      sif2.req_crash = 1'b0;
      sif2.req_fuel  = 1'b0;
      sif2.req_bonus = 1'b0;
      go(3);
      rst2 = 1'b0;
      exp2(12, 5'b11100);
      exp2(1036, 5'b11101);
      exp2(2060, 5'b11100);
      exp2(3664, 5'b11101);
      exp2(3701, 5'b00000);
      go(10);
      sif2.req_crash = 1'b1;
      go(11);
      sif2.req_crash = 1'b0;
      go(3700);
      rst2 = 1'b1;
      go(3702);
      rst2 = 1'b0;
      go(3720);
      done2 = 1'b1;
   end

   initial begin
      for (int i = 0; i < 10000 && !(done1 && done2); i++) @(posedge clk);
      if (!(done1 && done2)) begin
         n_vec++;
         n_bad++;
         $display("FAIL stimulus_timeout done1=%0d done2=%0d required both 1", done1, done2);
      end
      @(negedge clk);
      foreach (q1[i]) begin
         n_vec++;
         n_bad++;
         $display("FAIL dut1_missing never saw cyc=%0d outputs=%b", q1[i].cyc, q1[i].tup);
      end
      foreach (q2[i]) begin
         n_vec++;
         n_bad++;
         $display("FAIL dut2_missing never saw cyc=%0d outputs=%b", q2[i].cyc, q2[i].tup);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
